// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Package : risc_pkg
// Purpose : Shared state encodings and default sizes for the RISC pipeline
//           sequencer (risc_pipe_ctrl) and its valid-bit shifter.
// Contents: state_t (ST_CLR/ST_HALT/ST_RUN/ST_DRAIN), PC_W/DEPTH/RF_CLR_CYC
//           defaults.
// Revision: 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int PC_W_DEF       = 2;
  localparam int DEPTH_DEF      = 4;
  localparam int RF_CLR_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/risc_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: risc_pipe_ctrl_if
// Purpose  : Bundles the control inputs and sequencing outputs exchanged
//            between risc_pipe_ctrl and the RISC datapath.
// Modports : master - the sequencer (reads commands/hazards, drives PC,
//                     enables, valid bits and state)
//            slave  - the datapath / environment side
// Revision : 1.0 - initial release
// ============================================================================
interface risc_pipe_ctrl_if #(
  parameter int PC_W  = risc_pkg::PC_W_DEF,
  parameter int DEPTH = risc_pkg::DEPTH_DEF
);

  // commands and hazards
  logic              run;
  logic              step;
  logic              halt_req;
  logic              stall_req;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              wb_wr;

  // sequencing outputs
  logic [PC_W-1:0]   pc_out;
  logic              im_cs;
  logic              if_id_en;
  logic              id_exe_bubble;
  logic              flush;
  logic              rf_we;
  logic              rf_reset;
  logic [DEPTH-1:0]  valid_vec;
  risc_pkg::state_t  state;

  modport master (
    input  run, step, halt_req, stall_req, br_taken, br_target, wb_wr,
    output pc_out, im_cs, if_id_en, id_exe_bubble, flush, rf_we, rf_reset,
           valid_vec, state
  );

  modport slave (
    output run, step, halt_req, stall_req, br_taken, br_target, wb_wr,
    input  pc_out, im_cs, if_id_en, id_exe_bubble, flush, rf_we, rf_reset,
           valid_vec, state
  );

endinterface : risc_pipe_ctrl_if
`default_nettype wire

// File: rtl/risc_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module  : risc_valid_pipe
// Purpose : DEPTH-bit per-stage valid shifter. valid[0] is IF/ID, valid[DEPTH-1]
//           is WB. Each cycle bits move one stage older.
// Ports   : clk, reset_n (async active-low)
//           shift_in - value entering IF/ID on a fetch
//           hold_if  - keep IF/ID (decode stall)
//           bubble   - force 0 into ID/EXE
//           flush    - squash IF/ID and ID/EXE (overrides hold_if/bubble)
//           valid    - registered valid bits
// Revision: 1.0 - initial release
// ============================================================================
module risc_valid_pipe
  import risc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             shift_in,
  input  wire logic             hold_if,
  input  wire logic             bubble,
  input  wire logic             flush,
  output      logic [DEPTH-1:0] valid
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_nxt;

  assign w_nxt[0] = flush ? 1'b0 : (hold_if ? r_valid[0] : shift_in);
  assign w_nxt[1] = (flush | bubble) ? 1'b0 : r_valid[0];

  // Stages older than ID/EXE always advance; hazards never touch them.
  generate
    for (genvar k = 2; k < DEPTH; k++) begin : g_shift
      assign w_nxt[k] = r_valid[k-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_nxt;
    end
  end

  assign valid = r_valid;

endmodule : risc_valid_pipe
`default_nettype wire

// File: rtl/risc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : risc_pipe_ctrl
// Purpose : Sequencer for the 4-stage RISC pipeline. Generates the fetch PC,
//           instruction-memory select, register-file clear and write enable;
//           applies decode stalls and branch flushes; run/halt/step control.
// Ports   : clk      - rising-edge clock
//           reset_n  - asynchronous active-low reset
//           bus      - risc_pipe_ctrl_if.master (commands in, control out)
// Revision: 1.0 - initial release
// ============================================================================
module risc_pipe_ctrl
  import risc_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RF_CLR_CYC = RF_CLR_CYC_DEF
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  risc_pipe_ctrl_if.master   bus
);

  localparam int              CNT_W      = (RF_CLR_CYC > 1) ? $clog2(RF_CLR_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CLR_LAST = CNT_W'(RF_CLR_CYC - 1);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_rf_reset;
  logic [CNT_W-1:0]  r_clr_cnt;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              w_im_cs;
  logic              w_if_id_en;
  logic              w_bubble;
  logic              w_flush;
  logic              w_shift_in;
  logic              w_hold_if;
  logic [DEPTH-1:0]  w_valid;

  // --------------------------------------------------------------------------
  // State / PC / clear-counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_CLR;
      r_pc       <= '0;
      r_rf_reset <= 1'b1;
      r_clr_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == ST_CLR) begin
        r_clr_cnt  <= r_clr_cnt + 1'b1;
        // Drop the clear on the same edge that leaves CLR.
        r_rf_reset <= (r_clr_cnt != C_CLR_LAST);
      end else begin
        r_rf_reset <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and per-cycle control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_im_cs     = 1'b0;
    w_if_id_en  = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_shift_in  = 1'b0;
    w_hold_if   = 1'b0;

    case (r_state)
      ST_CLR: begin
        if (r_clr_cnt == C_CLR_LAST) w_state_nxt = ST_HALT;
      end

      ST_HALT: begin
        if (bus.run) begin
          w_state_nxt = ST_RUN;
        end else if (bus.step) begin
          // Single step: this cycle fetches, then the pipe drains.
          w_im_cs     = 1'b1;
          w_if_id_en  = 1'b1;
          w_shift_in  = 1'b1;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_RUN: begin
        if (bus.br_taken) begin
          // Redirect; the simultaneous stall (if any) is dropped.
          w_flush  = 1'b1;
          w_pc_nxt = bus.br_target;
        end else if (bus.stall_req) begin
          // Re-fetch the same address while IF/ID holds.
          w_im_cs   = 1'b1;
          w_bubble  = 1'b1;
          w_hold_if = 1'b1;
        end else begin
          w_im_cs    = 1'b1;
          w_if_id_en = 1'b1;
          w_shift_in = 1'b1;
          w_pc_nxt   = r_pc + 1'b1;
        end
        if (bus.halt_req) w_state_nxt = ST_DRAIN;
      end

      ST_DRAIN: begin
        // No fetches; hazards still act on the instructions in flight.
        if (bus.br_taken) begin
          w_flush = 1'b1;
        end else if (bus.stall_req) begin
          w_bubble  = 1'b1;
          w_hold_if = 1'b1;
        end
        if (w_valid == '0) w_state_nxt = ST_HALT;
      end

      default: w_state_nxt = ST_CLR;
    endcase
  end

  risc_valid_pipe #(
    .DEPTH (DEPTH)
  ) u_valid_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_in (w_shift_in),
    .hold_if  (w_hold_if),
    .bubble   (w_bubble),
    .flush    (w_flush),
    .valid    (w_valid)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc_out        = r_pc;
  assign bus.im_cs         = w_im_cs;
  assign bus.if_id_en      = w_if_id_en;
  assign bus.id_exe_bubble = w_bubble;
  assign bus.flush         = w_flush;
  // Only a genuine instruction reaching WB may write; bubbles carry valid=0.
  assign bus.rf_we         = (r_state != ST_CLR) & w_valid[DEPTH-1] & bus.wb_wr;
  assign bus.rf_reset      = r_rf_reset;
  assign bus.valid_vec     = w_valid;
  assign bus.state         = r_state;

endmodule : risc_pipe_ctrl
`default_nettype wire

// File: tb/tb_risc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc_pipe_ctrl
// Purpose : Directed self-checking bench for risc_pipe_ctrl (PC_W=2, DEPTH=4,
//           RF_CLR_CYC=2). Inputs change 1 time unit after the rising edge;
//           outputs are sampled between edges.
// Revision: 1.0 - initial release
// ============================================================================
module tb_risc_pipe_ctrl;
  import risc_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  risc_pipe_ctrl_if #(.PC_W(2), .DEPTH(4)) bus ();

  risc_pipe_ctrl #(
    .PC_W       (2),
    .DEPTH      (4),
    .RF_CLR_CYC (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int hi;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== ST_CLR || bus.pc_out !== 2'd0 || bus.valid_vec !== 4'b0000 ||
        bus.rf_reset !== 1'b1 || bus.rf_we !== 1'b0 || bus.im_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d pc=%0d valid=%b rf_reset=%b rf_we=%b im_cs=%b, need 0 0 0000 1 0 0",
               bus.state, bus.pc_out, bus.valid_vec, bus.rf_reset, bus.rf_we, bus.im_cs);
    end
    reset_n = 1'b1;
    #1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rf_reset === 1'b1) hi++;
      cyc();
    end
    checks++;
    if (hi != 2) begin
      errors++;
      $display("FAIL rf_reset_len: high for %0d cycles, need 2", hi);
    end
    checks++;
    if (bus.state !== ST_HALT || bus.pc_out !== 2'd0 || bus.rf_reset !== 1'b0) begin
      errors++;
      $display("FAIL clr_to_halt: state=%0d pc=%0d rf_reset=%b, need 1 0 0",
               bus.state, bus.pc_out, bus.rf_reset);
    end
  endtask

  task automatic test_run();
    logic [1:0] exp_pc [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] exp_v  [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] prev;
    bus.run   = 1'b1;
    bus.wb_wr = 1'b1;
    #1;
    checks++;
    if (bus.state !== ST_HALT || bus.im_cs !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle: state=%0d im_cs=%b, need 1 0", bus.state, bus.im_cs);
    end
    cyc();
    bus.run = 1'b0;
    prev = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus.state !== ST_RUN || bus.pc_out !== exp_pc[i] || bus.im_cs !== 1'b1 ||
          bus.if_id_en !== 1'b1 || bus.rf_we !== prev[3]) begin
        errors++;
        $display("FAIL run_cyc%0d: state=%0d pc=%0d im_cs=%b if_id_en=%b rf_we=%b, need 2 %0d 1 1 %b",
                 i, bus.state, bus.pc_out, bus.im_cs, bus.if_id_en, bus.rf_we, exp_pc[i], prev[3]);
      end
      cyc();
      checks++;
      if (bus.valid_vec !== exp_v[i]) begin
        errors++;
        $display("FAIL run_valid%0d: valid=%b, need %b", i, bus.valid_vec, exp_v[i]);
      end
      prev = exp_v[i];
    end
  endtask

  task automatic test_stall();
    logic [3:0] stall_v [2] = '{4'b1101, 4'b1001};
    logic [1:0] n_pc    [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic       n_we    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] n_v     [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    bus.stall_req = 1'b1;
    bus.wb_wr     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.pc_out !== 2'd2 || bus.im_cs !== 1'b1 || bus.if_id_en !== 1'b0 ||
          bus.id_exe_bubble !== 1'b1 || bus.flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d: pc=%0d im_cs=%b if_id_en=%b bubble=%b flush=%b, need 2 1 0 1 0",
                 i, bus.pc_out, bus.im_cs, bus.if_id_en, bus.id_exe_bubble, bus.flush);
      end
      cyc();
      checks++;
      if (bus.valid_vec !== stall_v[i] || bus.pc_out !== 2'd2) begin
        errors++;
        $display("FAIL stall_valid%0d: valid=%b pc=%0d, need %b 2",
                 i, bus.valid_vec, bus.pc_out, stall_v[i]);
      end
    end
    bus.stall_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.pc_out !== n_pc[i] || bus.rf_we !== n_we[i]) begin
        errors++;
        $display("FAIL hole_cyc%0d: pc=%0d rf_we=%b, need %0d %b",
                 i, bus.pc_out, bus.rf_we, n_pc[i], n_we[i]);
      end
      cyc();
      checks++;
      if (bus.valid_vec !== n_v[i]) begin
        errors++;
        $display("FAIL hole_valid%0d: valid=%b, need %b", i, bus.valid_vec, n_v[i]);
      end
    end
  endtask

  task automatic test_branch();
    bus.br_taken  = 1'b1;
    bus.stall_req = 1'b1;
    bus.br_target = 2'd1;
    #1;
    checks++;
    if (bus.pc_out !== 2'd2 || bus.flush !== 1'b1 || bus.im_cs !== 1'b0 ||
        bus.id_exe_bubble !== 1'b0 || bus.if_id_en !== 1'b0) begin
      errors++;
      $display("FAIL branch_ctl: pc=%0d flush=%b im_cs=%b bubble=%b if_id_en=%b, need 2 1 0 0 0",
               bus.pc_out, bus.flush, bus.im_cs, bus.id_exe_bubble, bus.if_id_en);
    end
    cyc();
    bus.br_taken  = 1'b0;
    bus.stall_req = 1'b0;
    checks++;
    if (bus.pc_out !== 2'd1 || bus.valid_vec !== 4'b1100) begin
      errors++;
      $display("FAIL branch_result: pc=%0d valid=%b, need 1 1100", bus.pc_out, bus.valid_vec);
    end
  endtask

  task automatic test_halt_step();
    int n;
    int fetches;
    bus.halt_req = 1'b1;
    #1;
    checks++;
    if (bus.state !== ST_RUN || bus.im_cs !== 1'b1) begin
      errors++;
      $display("FAIL halt_req_cyc: state=%0d im_cs=%b, need 2 1", bus.state, bus.im_cs);
    end
    cyc();
    bus.halt_req = 1'b0;
    checks++;
    if (bus.state !== ST_DRAIN || bus.pc_out !== 2'd2 || bus.valid_vec !== 4'b1001) begin
      errors++;
      $display("FAIL drain_entry: state=%0d pc=%0d valid=%b, need 3 2 1001",
               bus.state, bus.pc_out, bus.valid_vec);
    end
    n = 0;
    fetches = 0;
    while (bus.state !== ST_HALT && n < 10) begin
      if (bus.im_cs !== 1'b0) fetches++;
      cyc();
      n++;
    end
    checks++;
    if (bus.state !== ST_HALT || n > 5 || fetches != 0 || bus.pc_out !== 2'd2 ||
        bus.valid_vec !== 4'b0000) begin
      errors++;
      $display("FAIL drain_to_halt: state=%0d cycles=%0d fetches=%0d pc=%0d valid=%b, need 1 <=5 0 2 0000",
               bus.state, n, fetches, bus.pc_out, bus.valid_vec);
    end
    bus.step = 1'b1;
    #1;
    checks++;
    if (bus.state !== ST_HALT || bus.im_cs !== 1'b1 || bus.if_id_en !== 1'b1) begin
      errors++;
      $display("FAIL step_fetch: state=%0d im_cs=%b if_id_en=%b, need 1 1 1",
               bus.state, bus.im_cs, bus.if_id_en);
    end
    cyc();
    bus.step = 1'b0;
    checks++;
    if (bus.state !== ST_DRAIN || bus.pc_out !== 2'd3 || bus.valid_vec !== 4'b0001) begin
      errors++;
      $display("FAIL step_result: state=%0d pc=%0d valid=%b, need 3 3 0001",
               bus.state, bus.pc_out, bus.valid_vec);
    end
    n = 0;
    fetches = 0;
    while (bus.state !== ST_HALT && n < 10) begin
      if (bus.im_cs !== 1'b0) fetches++;
      cyc();
      n++;
    end
    checks++;
    if (bus.state !== ST_HALT || n > 5 || fetches != 0 || bus.pc_out !== 2'd3) begin
      errors++;
      $display("FAIL step_to_halt: state=%0d cycles=%0d fetches=%0d pc=%0d, need 1 <=5 0 3",
               bus.state, n, fetches, bus.pc_out);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bus.run   = 1'b1;
    bus.wb_wr = 1'b1;
    cyc();
    bus.run = 1'b0;
    repeat (4) cyc();
    #1;
    checks++;
    if (bus.valid_vec !== 4'b1111 || bus.pc_out !== 2'd3 || bus.rf_we !== 1'b1) begin
      errors++;
      $display("FAIL prereset_run: valid=%b pc=%0d rf_we=%b, need 1111 3 1",
               bus.valid_vec, bus.pc_out, bus.rf_we);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.pc_out !== 2'd0 || bus.valid_vec !== 4'b0000 || bus.rf_we !== 1'b0 ||
        bus.rf_reset !== 1'b1 || bus.state !== ST_CLR) begin
      errors++;
      $display("FAIL async_reset: pc=%0d valid=%b rf_we=%b rf_reset=%b state=%0d, need 0 0000 0 1 0",
               bus.pc_out, bus.valid_vec, bus.rf_we, bus.rf_reset, bus.state);
    end
    cyc();
    reset_n = 1'b1;
    n = 0;
    while (bus.state !== ST_HALT && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.state !== ST_HALT || bus.rf_reset !== 1'b0) begin
      errors++;
      $display("FAIL rereset_halt: state=%0d rf_reset=%b, need 1 0", bus.state, bus.rf_reset);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.halt_req  = 1'b0;
    bus.stall_req = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 2'd0;
    bus.wb_wr     = 1'b1;

    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_halt_step();
    test_reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_risc_pipe_ctrl
`default_nettype wire
